memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 165 ++++++++++++++++
 tb/tb_memory_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: forwards ALU results, issues aligned loads/stores on the
// data bus, waits for the response and produces a registered writeback bundle.
module memory_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_result,
    input  logic [XLEN-1:0] in_memdata,
    input  logic            in_memread,
    input  logic            in_memwrite,
    input  logic            in_regwrite,
    input  logic            in_mem_unsigned,
    input  logic [1:0]      in_msize,
    input  logic [4:0]      in_dst,
    input  logic            flush,
    output logic            dreq_valid,
    output logic [XLEN-1:0] dreq_addr,
    output logic [1:0]      dreq_size,
    output logic [7:0]      dreq_strobe,
    output logic [XLEN-1:0] dreq_data,
    input  logic            dresp_data_ok,
    input  logic [XLEN-1:0] dresp_data,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_dst,
    output logic            out_regwrite,
    output logic            out_misalign
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state, state_next;
    logic            kill;
    logic [XLEN-1:0] req_addr, req_data, req_pc;
    logic [1:0]      req_size;
    logic [7:0]      req_strobe;
    logic            req_write, req_unsigned, req_regwrite;
    logic [4:0]      req_dst;

    logic            is_mem, misaligned, accept, start_mem;
    logic [7:0]      strobe_base;
    logic [XLEN-1:0] load_shifted, load_result;

    assign is_mem    = in_memread | in_memwrite;
    assign accept    = (state == S_IDLE) && in_valid && !flush;
    assign start_mem = accept && is_mem && !misaligned;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        misaligned  = 1'b0;
        strobe_base = 8'h01;
        case (in_msize)
            2'd0: begin misaligned = 1'b0;              strobe_base = 8'h01; end
            2'd1: begin misaligned = in_result[0];      strobe_base = 8'h03; end
            2'd2: begin misaligned = |in_result[1:0];   strobe_base = 8'h0F; end
            default: begin misaligned = |in_result[2:0]; strobe_base = 8'hFF; end
        endcase
    end

    // Bus lanes are byte-addressed within the doubleword, so shift by the low address bits.
    always_comb begin
        load_shifted = dresp_data >> {req_addr[2:0], 3'b000};
        load_result  = load_shifted;
        case (req_size)
            2'd0: load_result = {{(XLEN-8){!req_unsigned && load_shifted[7]}}, load_shifted[7:0]};
            2'd1: load_result = {{(XLEN-16){!req_unsigned && load_shifted[15]}}, load_shifted[15:0]};
            2'd2: load_result = {{(XLEN-32){!req_unsigned && load_shifted[31]}}, load_shifted[31:0]};
            default: load_result = load_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start_mem)     state_next = S_WAIT;
            S_WAIT:  if (dresp_data_ok) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        dreq_valid = 1'b0;
        case (state)
            S_IDLE:  in_ready   = 1'b1;
            S_WAIT:  dreq_valid = 1'b1;
            default: ;
        endcase
    end

    assign dreq_addr   = req_addr;
    assign dreq_size   = req_size;
    assign dreq_strobe = req_strobe;
    assign dreq_data   = req_data;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kill         <= 1'b0;
            req_addr     <= '0;
            req_data     <= '0;
            req_pc       <= '0;
            req_size     <= '0;
            req_strobe   <= '0;
            req_write    <= 1'b0;
            req_unsigned <= 1'b0;
            req_regwrite <= 1'b0;
            req_dst      <= '0;
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_result   <= '0;
            out_dst      <= '0;
            out_regwrite <= 1'b0;
            out_misalign <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (accept && (!is_mem || misaligned)) begin
                    out_valid    <= 1'b1;
                    out_pc       <= in_pc;
                    out_result   <= in_result;
                    out_dst      <= in_dst;
                    out_regwrite <= in_regwrite && !is_mem;
                    out_misalign <= is_mem;
                end else if (start_mem) begin
                    kill         <= 1'b0;
                    req_addr     <= in_result;
                    req_size     <= in_msize;
                    req_strobe   <= in_memwrite ? 8'(strobe_base << in_result[2:0]) : 8'h00;
                    req_data     <= in_memwrite ? (in_memdata << {in_result[2:0], 3'b000}) : '0;
                    req_write    <= in_memwrite;
                    req_unsigned <= in_mem_unsigned;
                    req_regwrite <= in_regwrite;
                    req_pc       <= in_pc;
                    req_dst      <= in_dst;
                end
            end else begin
                if (flush) kill <= 1'b1;
                // A killed access still finishes on the bus; only its writeback is dropped.
                if (dresp_data_ok) begin
                    kill <= 1'b0;
                    if (!kill && !flush) begin
                        out_valid    <= 1'b1;
                        out_pc       <= req_pc;
                        out_dst      <= req_dst;
                        out_result   <= req_write ? req_addr : load_result;
                        out_regwrite <= req_regwrite && !req_write;
                        out_misalign <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, corner-case
// sequences (flush, early data_ok, reset mid-access) and randomized transactions.
module tb_memory_stage;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_pc, in_result, in_memdata;
    logic            in_memread, in_memwrite, in_regwrite, in_mem_unsigned;
    logic [1:0]      in_msize;
    logic [4:0]      in_dst;
    logic            flush;
    logic            dreq_valid;
    logic [XLEN-1:0] dreq_addr, dreq_data;
    logic [1:0]      dreq_size;
    logic [7:0]      dreq_strobe;
    logic            dresp_data_ok;
    logic [XLEN-1:0] dresp_data;
    logic            out_valid, out_regwrite, out_misalign;
    logic [XLEN-1:0] out_pc, out_result;
    logic [4:0]      out_dst;

    always #5 clk = ~clk;

    memory_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_result(in_result), .in_memdata(in_memdata),
        .in_memread(in_memread), .in_memwrite(in_memwrite),
        .in_regwrite(in_regwrite), .in_mem_unsigned(in_mem_unsigned),
        .in_msize(in_msize), .in_dst(in_dst), .flush(flush),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
        .out_dst(out_dst), .out_regwrite(out_regwrite), .out_misalign(out_misalign)
    );

    typedef struct {
        logic        rd, wr, uns, rw;
        logic [1:0]  size;
        logic [63:0] result, memdata, resp, pc;
        logic [4:0]  dst;
        int          lat;
        logic [63:0] exp_result;
        logic        exp_rw, exp_mis, chk_result;
        logic [7:0]  exp_strobe;
        logic [63:0] exp_data;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_pc = '0; in_result = '0; in_memdata = '0;
        in_memread = 1'b0; in_memwrite = 1'b0; in_regwrite = 1'b0;
        in_mem_unsigned = 1'b0; in_msize = 2'd0; in_dst = '0; flush = 1'b0;
    endtask

    task automatic drive_op(input vec_t v);
        in_valid = 1'b1; in_pc = v.pc; in_result = v.result; in_memdata = v.memdata;
        in_memread = v.rd; in_memwrite = v.wr; in_regwrite = v.rw;
        in_mem_unsigned = v.uns; in_msize = v.size; in_dst = v.dst;
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic uns, input logic rw,
                                input logic [1:0] size, input logic [63:0] result,
                                input logic [63:0] memdata, input logic [63:0] resp, input int lat,
                                input logic [63:0] exp_result, input logic exp_rw,
                                input logic exp_mis, input logic [7:0] exp_strobe,
                                input logic [63:0] exp_data);
        vec_t v;
        v.rd = rd; v.wr = wr; v.uns = uns; v.rw = rw; v.size = size;
        v.result = result; v.memdata = memdata; v.resp = resp; v.lat = lat;
        v.pc = 64'h0; v.dst = 5'd0;
        v.exp_result = exp_result; v.exp_rw = exp_rw; v.exp_mis = exp_mis;
        v.chk_result = !exp_mis; v.exp_strobe = exp_strobe; v.exp_data = exp_data;
        return v;
    endfunction

    // Reference model: assembles bytes lane by lane from the access rules.
    function automatic vec_t model(input vec_t v);
        int          nbytes, off;
        logic [63:0] val;
        vec_t        r;
        r = v;
        nbytes = 1 << v.size;
        off = int'(v.result % 64'd8);
        r.exp_mis = (v.rd || v.wr) && ((v.result % 64'(nbytes)) != 64'd0);
        r.chk_result = !r.exp_mis;
        r.exp_strobe = 8'h00;
        r.exp_data = 64'h0;
        r.exp_result = v.result;
        if (v.wr && !r.exp_mis) begin
            for (int i = 0; i < nbytes; i++) r.exp_strobe[off + i] = 1'b1;
            r.exp_data = v.memdata << (8 * off);
        end
        if (v.rd && !r.exp_mis) begin
            val = 64'h0;
            for (int i = 0; i < nbytes; i++) val[8*i +: 8] = v.resp[8*(off + i) +: 8];
            if (!v.uns && val[8*nbytes - 1])
                for (int i = nbytes; i < 8; i++) val[8*i +: 8] = 8'hFF;
            r.exp_result = val;
        end
        r.exp_rw = (v.rd || v.wr) ? (v.rd && !r.exp_mis && v.rw) : v.rw;
        return r;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        drive_op(v);
        step();
        in_valid = 1'b0;
        if ((v.rd || v.wr) && !v.exp_mis) begin
            for (int c = 1; c <= v.lat; c++) begin
                check({tag, ".dreq_valid"}, 64'(dreq_valid), 64'd1);
                check({tag, ".dreq_addr"}, dreq_addr, v.result);
                check({tag, ".dreq_size"}, 64'(dreq_size), 64'(v.size));
                check({tag, ".dreq_strobe"}, 64'(dreq_strobe), 64'(v.exp_strobe));
                check({tag, ".dreq_data"}, dreq_data, v.exp_data);
                check({tag, ".wait_out_valid"}, 64'(out_valid), 64'd0);
                if (c == v.lat) begin
                    dresp_data_ok = 1'b1;
                    dresp_data = v.resp;
                end else begin
                    dresp_data = {$urandom, $urandom};
                end
                step();
                dresp_data_ok = 1'b0;
            end
        end
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".dreq_valid_after"}, 64'(dreq_valid), 64'd0);
        if (v.chk_result) check({tag, ".out_result"}, out_result, v.exp_result);
        check({tag, ".out_regwrite"}, 64'(out_regwrite), 64'(v.exp_rw));
        check({tag, ".out_misalign"}, 64'(out_misalign), 64'(v.exp_mis));
        check({tag, ".out_pc"}, out_pc, v.pc);
        check({tag, ".out_dst"}, 64'(out_dst), 64'(v.dst));
        step();
        check({tag, ".out_valid_drop"}, 64'(out_valid), 64'd0);
        if (v.chk_result) check({tag, ".out_result_hold"}, out_result, v.exp_result);
    endtask

    vec_t vecs[12];
    vec_t rv;

    initial begin
        drive_idle();
        dresp_data_ok = 1'b0;
        dresp_data = '0;
        reset = 1'b0;
        #12;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.dreq_valid", 64'(dreq_valid), 64'd0);
        check("reset.dreq_addr", dreq_addr, 64'd0);
        check("reset.dreq_strobe", 64'(dreq_strobe), 64'd0);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.out_result", out_result, 64'd0);
        check("reset.out_regwrite", 64'(out_regwrite), 64'd0);
        step();
        reset = 1'b1;
        step();
        check("post_reset.in_ready", 64'(in_ready), 64'd1);

        //          rd wr un rw sz  result                 memdata                resp                   lat exp_result             rw mis strobe data
        vecs[0]  = mk(0, 0, 0, 1, 0, 64'h1234,              64'h0,                 64'h0,                 1, 64'h1234,              1, 0, 8'h00, 64'h0);
        vecs[1]  = mk(1, 0, 0, 1, 0, 64'h1003,              64'h0,                 64'h0000_0000_80FF_0000, 3, 64'hFFFF_FFFF_FFFF_FF80, 1, 0, 8'h00, 64'h0);
        vecs[2]  = mk(1, 0, 1, 1, 0, 64'h1003,              64'h0,                 64'h0000_0000_80FF_0000, 3, 64'h80,                1, 0, 8'h00, 64'h0);
        vecs[3]  = mk(0, 1, 0, 1, 1, 64'h2006,              64'hBEEF,              64'h0,                 2, 64'h2006,              0, 0, 8'hC0, 64'hBEEF_0000_0000_0000);
        vecs[4]  = mk(1, 0, 0, 1, 2, 64'h3002,              64'h0,                 64'h0,                 1, 64'h0,                 0, 1, 8'h00, 64'h0);
        vecs[5]  = mk(1, 0, 0, 1, 3, 64'h4000,              64'h0,                 64'h8123_4567_89AB_CDEF, 1, 64'h8123_4567_89AB_CDEF, 1, 0, 8'h00, 64'h0);
        vecs[6]  = mk(1, 0, 0, 1, 1, 64'h5006,              64'h0,                 64'hF00D_0000_0000_0000, 2, 64'hFFFF_FFFF_FFFF_F00D, 1, 0, 8'h00, 64'h0);
        vecs[7]  = mk(1, 0, 1, 1, 2, 64'h6004,              64'h0,                 64'h8000_0001_0000_0000, 1, 64'h8000_0001,          1, 0, 8'h00, 64'h0);
        vecs[8]  = mk(1, 0, 0, 1, 2, 64'h6004,              64'h0,                 64'h8000_0001_0000_0000, 1, 64'hFFFF_FFFF_8000_0001, 1, 0, 8'h00, 64'h0);
        vecs[9]  = mk(0, 1, 0, 1, 0, 64'h7005,              64'hAB,                64'h0,                 1, 64'h7005,              0, 0, 8'h20, 64'h0000_AB00_0000_0000);
        vecs[10] = mk(0, 1, 0, 0, 3, 64'h8000,              64'h0123_4567_89AB_CDEF, 64'h0,               4, 64'h8000,              0, 0, 8'hFF, 64'h0123_4567_89AB_CDEF);
        vecs[11] = mk(0, 1, 0, 1, 3, 64'h8004,              64'h55,                64'h0,                 1, 64'h0,                 0, 1, 8'h00, 64'h0);

        for (int i = 0; i < 12; i++) begin
            vecs[i].pc  = 64'h1000_0000 + 64'(i * 4);
            vecs[i].dst = 5'(i + 5);
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Flush while waiting: bus request stays up, writeback is dropped.
        rv = vecs[5];
        rv.result = 64'h9000;
        drive_op(rv);
        step();
        drive_idle();
        check("flushwait.dreq_valid0", 64'(dreq_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flushwait.dreq_valid1", 64'(dreq_valid), 64'd1);
        check("flushwait.out_valid1", 64'(out_valid), 64'd0);
        step();
        check("flushwait.dreq_valid2", 64'(dreq_valid), 64'd1);
        check("flushwait.dreq_addr", dreq_addr, 64'h9000);
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
        check("flushwait.out_valid", 64'(out_valid), 64'd0);
        check("flushwait.dreq_valid_end", 64'(dreq_valid), 64'd0);
        check("flushwait.in_ready", 64'(in_ready), 64'd1);
        step();
        check("flushwait.out_valid_late", 64'(out_valid), 64'd0);
        run_txn(vecs[0], "after_flush");

        // Flush in IDLE drops both an ALU op and a memory op.
        drive_op(vecs[0]);
        flush = 1'b1;
        step();
        check("flushidle_alu.out_valid", 64'(out_valid), 64'd0);
        drive_op(vecs[5]);
        step();
        drive_idle();
        check("flushidle_mem.dreq_valid", 64'(dreq_valid), 64'd0);
        check("flushidle_mem.out_valid", 64'(out_valid), 64'd0);

        // data_ok coinciding with acceptance is ignored.
        rv = vecs[5];
        rv.result = 64'hA008;
        rv.pc = 64'h44;
        drive_op(rv);
        dresp_data_ok = 1'b1;
        dresp_data = 64'hDEAD;
        step();
        drive_idle();
        dresp_data_ok = 1'b0;
        check("early_ok.dreq_valid", 64'(dreq_valid), 64'd1);
        check("early_ok.out_valid", 64'(out_valid), 64'd0);
        dresp_data = 64'h1122_3344_5566_7788;
        dresp_data_ok = 1'b1;
        step();
        dresp_data_ok = 1'b0;
        check("early_ok.out_valid_done", 64'(out_valid), 64'd1);
        check("early_ok.out_result", out_result, 64'h1122_3344_5566_7788);
        check("early_ok.out_pc", out_pc, 64'h44);
        step();

        // Reset asserted mid-access.
        drive_op(vecs[5]);
        step();
        drive_idle();
        check("rst_wait.dreq_valid_before", 64'(dreq_valid), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_wait.dreq_valid", 64'(dreq_valid), 64'd0);
        check("rst_wait.out_valid", 64'(out_valid), 64'd0);
        check("rst_wait.in_ready", 64'(in_ready), 64'd1);
        check("rst_wait.dreq_addr", dreq_addr, 64'd0);
        step();
        reset = 1'b1;
        step();
        check("rst_wait.in_ready_after", 64'(in_ready), 64'd1);
        check("rst_wait.out_valid_after", 64'(out_valid), 64'd0);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            rv.rd = (kind == 1);
            rv.wr = (kind == 2);
            rv.uns = 1'($urandom_range(0, 1));
            rv.rw = 1'($urandom_range(0, 1));
            rv.size = 2'($urandom_range(0, 3));
            rv.result = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) rv.result[2:0] = 3'($urandom_range(0, 7) & ~((1 << rv.size) - 1));
            rv.memdata = {$urandom, $urandom};
            rv.resp = {$urandom, $urandom};
            rv.pc = {$urandom, $urandom};
            rv.dst = 5'($urandom_range(0, 31));
            rv.lat = int'($urandom_range(1, 4));
            rv = model(rv);
            run_txn(rv, $sformatf("rand%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
